// File: rtl/pipe_memory_sequencer_if.sv
// Pipeline request/response and data-memory bus bundle for the memory sequencer.
// The master modport is the sequencer's view; slave is the pipeline/memory side.
interface pipe_memory_sequencer_if;
  logic        reqValid;
  logic        reqWrite;
  logic [31:0] reqAddress;
  logic [3:0]  reqByteSelect;
  logic [31:0] reqWriteData;
  logic        reqReady;
  logic        pipeStall;
  logic        respValid;
  logic [31:0] loadData;
  logic        accessFault;
  logic        memEnable;
  logic        memWriteEnable;
  logic [3:0]  memByteSelect;
  logic [31:0] memAddress;
  logic [31:0] memDataWrite;
  logic [31:0] memDataRead;
  logic        memBusy;

  modport master (
    input  reqValid, reqWrite, reqAddress, reqByteSelect, reqWriteData,
    input  memDataRead, memBusy,
    output reqReady, pipeStall, respValid, loadData, accessFault,
    output memEnable, memWriteEnable, memByteSelect, memAddress, memDataWrite
  );

  modport slave (
    output reqValid, reqWrite, reqAddress, reqByteSelect, reqWriteData,
    output memDataRead, memBusy,
    input  reqReady, pipeStall, respValid, loadData, accessFault,
    input  memEnable, memWriteEnable, memByteSelect, memAddress, memDataWrite
  );
endinterface

// File: rtl/pipe_memory_sequencer.sv
// Sequences one pipeline load/store at a time onto the single-port data memory bus,
// stalling the pipeline while outstanding and faulting an access that hangs too long.
module pipe_memory_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                     clk,
  input logic                     rst,
  pipe_memory_sequencer_if.master bus
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

  stateT         stateQ, stateD;
  logic          writeQ;
  logic [31:0]   addrQ;
  logic [3:0]    byteSelQ;
  logic [31:0]   wdataQ;
  logic [CW-1:0] countQ;
  logic          faultQ;
  logic [31:0]   loadQ;

  logic accept;
  logic emptyReq;
  logic complete;
  logic timeoutHit;

  always_comb begin
    stateD     = stateQ;
    accept     = 1'b0;
    emptyReq   = 1'b0;
    complete   = 1'b0;
    timeoutHit = 1'b0;
    case (stateQ)
      IDLE: begin
        if (bus.reqValid) begin
          if (|bus.reqByteSelect) begin
            accept = 1'b1;
            stateD = ACCESS;
          end else begin
            emptyReq = 1'b1;
            stateD   = RESP;
          end
        end
      end
      ACCESS: begin
        // Completion takes priority over a timeout landing on the same cycle.
        if (!bus.memBusy) begin
          complete = 1'b1;
          stateD   = RESP;
        end else if (TIMEOUT_EN && countQ == LAST_COUNT) begin
          timeoutHit = 1'b1;
          stateD     = IDLE;
        end
      end
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= IDLE;
      writeQ   <= 1'b0;
      addrQ    <= '0;
      byteSelQ <= '0;
      wdataQ   <= '0;
      countQ   <= '0;
      faultQ   <= 1'b0;
      loadQ    <= '0;
    end else begin
      stateQ <= stateD;
      faultQ <= timeoutHit;
      if (accept) begin
        writeQ   <= bus.reqWrite;
        addrQ    <= bus.reqAddress;
        byteSelQ <= bus.reqByteSelect;
        wdataQ   <= bus.reqWriteData;
        countQ   <= '0;
      end else if (stateQ == ACCESS && bus.memBusy) begin
        countQ <= countQ + CW'(1);
      end
      // Stores and faulted accesses leave the last load result in place.
      if (emptyReq) begin
        loadQ <= '0;
      end else if (complete && !writeQ) begin
        loadQ <= bus.memDataRead;
      end
    end
  end

  logic inAccess;
  assign inAccess = (stateQ == ACCESS);

  assign bus.reqReady       = (stateQ == IDLE);
  assign bus.pipeStall      = inAccess;
  assign bus.respValid      = (stateQ == RESP);
  assign bus.loadData       = loadQ;
  assign bus.accessFault    = faultQ;
  assign bus.memEnable      = inAccess;
  assign bus.memWriteEnable = inAccess & writeQ;
  assign bus.memByteSelect  = inAccess ? byteSelQ : 4'b0000;
  assign bus.memAddress     = inAccess ? addrQ : 32'h0;
  assign bus.memDataWrite   = inAccess ? wdataQ : 32'h0;

endmodule
